// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end: FSM state encoding,
// word widths and the 2-bit command codes carried in the top of each word.
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_WORD_W = SPI_DATA_W + 2;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True when a completed word's command field agrees with the state that received it.
  function automatic logic cmd_match(input state_t st, input logic [1:0] cmd);
    case (st)
      WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      READ_ADD:  return cmd == CMD_RD_ADDR;
      READ_DATA: return cmd == CMD_RD_DATA;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/spi_piso_tx.sv
// MISO serialiser: loads the RAM read byte and shifts it out MSB first, one bit
// per clock; abort (slave deselect) drops the transfer immediately.
module spi_piso_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_abort,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_miso
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_busy;

  assign w_busy = (r_cnt != '0);
  assign o_miso = w_busy & r_sh[DATA_W-1];

  // A load while a byte is still going out is dropped, not restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_abort) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load && !w_busy) begin
      r_sh  <= i_data;
      r_cnt <= CNT_W'(DATA_W);
    end else if (w_busy) begin
      r_sh  <= {r_sh[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames into command words for the RAM
// and serialises the RAM read byte onto MISO. SPI_CMD_CHECK_EN adds a cmd-field check.
module spi_slave_fsm #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              cmd_err
);
  import spi_pkg::*;

  localparam int RX_W  = DATA_W + 2;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RX_W);

  state_t            r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [RX_W-1:0]   r_word, r_rx_data;
  logic              r_rx_valid, r_cmd_err, r_rd_seen;
  logic              w_in_word, w_shift, w_done, w_ok;
  logic [RX_W-1:0]   w_word;

  assign w_in_word = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
  assign w_shift   = w_in_word && !SS_n && (r_cnt < CNT_FULL);
  assign w_done    = w_shift && (r_cnt == CNT_LAST);
  assign w_word    = {r_word[RX_W-2:0], MOSI};

`ifdef SPI_CMD_CHECK_EN
  assign w_ok = cmd_match(r_state, w_word[RX_W-1 -: 2]);
`else
  assign w_ok = 1'b1;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (!SS_n) w_nxt = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)          w_nxt = IDLE;
        else if (!MOSI)    w_nxt = WRITE;
        else if (r_rd_seen) w_nxt = READ_DATA;
        else               w_nxt = READ_ADD;
      end
      default: if (SS_n) w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Counter saturates at RX_W so trailing bits in a frame are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (SS_n || !w_in_word) begin
        r_cnt  <= '0;
        r_word <= '0;
      end else if (w_shift) begin
        r_cnt  <= r_cnt + 1'b1;
        r_word <= w_word;
      end
      if (w_done) begin
        if (w_ok) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= w_word;
          if (r_state == READ_ADD)       r_rd_seen <= 1'b1;
          else if (r_state == READ_DATA) r_rd_seen <= 1'b0;
        end else begin
          r_cmd_err <= 1'b1;
        end
      end
    end
  end

  spi_piso_tx #(.DATA_W(DATA_W)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_abort (SS_n),
    .i_load  (tx_valid && (r_state == READ_DATA)),
    .i_data  (tx_data),
    .o_miso  (MISO)
  );

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign cmd_err  = r_cmd_err;
endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench for spi_slave_fsm: frames push expected strobes, a monitor
// pops them on rx_valid/cmd_err; a small RAM model answers read-data words.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO, rx_valid, cmd_err;
  logic [9:0] rx_data;
  logic [7:0] ram_byte = 8'hA5;
  logic [7:0] pat;

  int checks = 0, errors = 0;

  typedef struct { bit is_err; logic [9:0] data; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_slave_fsm #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .cmd_err(cmd_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bit_out(input logic b);
    MOSI = b;
    tick();
    chk("miso_quiet", int'(MISO), 0);
  endtask

  task automatic start_frame(input logic mode, input logic [9:0] w, input int nbits);
    SS_n = 1'b0;
    bit_out(1'b0);
    bit_out(mode);
    for (int i = 9; i > 9 - nbits; i--) bit_out(w[i]);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    chk("idle_after_ss", int'(dut.r_state == IDLE), 1);
  endtask

  function automatic void exp_rx(input logic [9:0] d);
    exp_t e; e.is_err = 1'b0; e.data = d; exp_q.push_back(e);
  endfunction

  function automatic void exp_err(input logic [9:0] d);
    exp_t e; e.is_err = 1'b1; e.data = d; exp_q.push_back(e);
  endfunction

  // Monitor: every strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid || cmd_err) begin
        chk("strobe_excl", int'(rx_valid && cmd_err), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", int'({rx_valid, cmd_err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", int'(cmd_err), int'(e.is_err));
          if (!e.is_err) chk("rx_data", int'(rx_data), int'(e.data));
        end
      end
    end
  end

  // RAM model: answers a read-data word one cycle after its strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && rx_data[9:8] == 2'b11) begin
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = ram_byte;
        @(posedge clk); #1;
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_miso", int'(MISO), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_cmd_err", int'(cmd_err), 0);
    chk("rst_state", int'(dut.r_state == IDLE), 1);
    chk("rst_rd_seen", int'(dut.r_rd_seen), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    chk("txv_outside_read", int'(MISO), 0);
    tick();
    chk("txv_outside_read2", int'(MISO), 0);

    exp_rx(10'h03C);
    start_frame(1'b0, 10'h03C, 10);
    end_frame();

    exp_rx(10'h1A5);
    start_frame(1'b0, 10'h1A5, 10);
    repeat (5) bit_out(1'b1);
    end_frame();

    exp_rx(10'h23C);
    start_frame(1'b1, 10'h23C, 10);
    chk("route_rd_add", int'(dut.r_state == READ_ADD), 1);
    end_frame();
    chk("rd_seen_set", int'(dut.r_rd_seen), 1);

    exp_rx(10'h300);
    ram_byte = 8'hA5; pat = 8'hA5;
    start_frame(1'b1, 10'h300, 10);
    chk("route_rd_data", int'(dut.r_state == READ_DATA), 1);
    tick();
    chk("miso_e12", int'(MISO), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("miso_bit", int'(MISO), int'(pat[7-k]));
    end
    tick();
    chk("miso_e21", int'(MISO), 0);
    end_frame();
    chk("rd_seen_clr", int'(dut.r_rd_seen), 0);

    start_frame(1'b1, 10'h3FF, 5);
    chk("abort_route_add", int'(dut.r_state == READ_ADD), 1);
    end_frame();

    exp_rx(10'h2AA);
    start_frame(1'b1, 10'h2AA, 10);
    end_frame();
    chk("rd_seen_set2", int'(dut.r_rd_seen), 1);

    start_frame(1'b1, 10'h3FF, 5);
    chk("abort_route_data", int'(dut.r_state == READ_DATA), 1);
    end_frame();
    chk("rd_seen_kept", int'(dut.r_rd_seen), 1);

    exp_rx(10'h3C3);
    ram_byte = 8'h5A;
    start_frame(1'b1, 10'h3C3, 10);
    repeat (6) tick();
    chk("miso_bit3_pre_rst", int'(MISO), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_miso", int'(MISO), 0);
    chk("rst_mid_rx_valid", int'(rx_valid), 0);
    chk("rst_mid_state", int'(dut.r_state == IDLE), 1);
    chk("rst_mid_rd_seen", int'(dut.r_rd_seen), 0);
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SPI_CMD_CHECK_EN
    exp_err(10'h23C);
`else
    exp_rx(10'h23C);
`endif
    start_frame(1'b0, 10'h23C, 10);
    end_frame();

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Serial front end for the SPI RAM stage. Deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the RAM.
- Captures the RAM's read byte (tx_data/tx_valid) and serialises it onto MISO.
- The SPI bit clock is the system clock clk: one MOSI bit is sampled per rising edge while SS_n is low.

Parameters:
- DATA_W, 8, RAM data width. Command word width WORD_W = DATA_W+2 (fixed, not overridable).

Ports:
- clk  in  1  system/SPI clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  slave select, active low, frames a transaction
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first
- rx_data  out  WORD_W  command word to RAM ({cmd[1:0], payload[DATA_W-1:0]})
- rx_valid  out  1  single-cycle strobe, rx_data valid
- tx_data  in  DATA_W  read byte from RAM
- tx_valid  in  1  tx_data valid strobe from RAM
- cmd_err  out  1  command mismatch strobe (see Optional Feature; constant 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; MISO=0, rx_data=0, rx_valid=0, cmd_err=0; bit counter=0; rd_addr_seen=0; TX shifter cleared. Applies mid-frame and mid-serialisation; no pending strobe survives.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 at edge E0 -> CHK_CMD. MOSI at E0 is ignored.
- CHK_CMD: MOSI at E1 is the mode bit. 0 -> WRITE. 1 with rd_addr_seen=0 -> READ_ADD. 1 with rd_addr_seen=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: edges E2..E11 shift MOSI into the word MSB first; the counter runs 0..WORD_W.
  - After E11: rx_data = assembled word, rx_valid=1 for exactly one cycle.
  - Further MOSI bits in the frame are ignored; no second strobe.
- rd_addr_seen: set on the READ_ADD strobe; cleared on the READ_DATA strobe.
- READ_DATA response:
  - RAM returns tx_valid one cycle after rx_valid (sampled at E13).
  - On the edge tx_valid=1 is seen in READ_DATA: load tx_data; MISO=tx_data[7] after that edge, then one bit per edge, d0 after E20; MISO=0 after E21.
  - tx_valid outside READ_DATA, or a second tx_valid during serialisation, is ignored.
- MISO=0 whenever not actively serialising.
- SS_n=1 at any edge, any state: next state IDLE; counter and TX shifter cleared; MISO=0.
  - A partial word (<10 bits) never produces rx_valid.
  - rd_addr_seen is retained across frames.
- SS_n high and low on consecutive edges: a fresh frame starts from IDLE (E0 rule applies).
- rx_valid and cmd_err are mutually exclusive and never asserted back to back within one frame.

Optional Feature:
- Macro SPI_CMD_CHECK_EN.
- Defined: at word completion, the word's cmd[1:0] must match the state: WRITE expects 00 or 01, READ_ADD expects 10, READ_DATA expects 11.
  - On mismatch: rx_valid suppressed, cmd_err=1 for one cycle, rd_addr_seen unchanged.
- Undefined: no check; every completed word strobes rx_valid; cmd_err tied 0.

Decomposition:
- Package spi_pkg: state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA); DATA_W/WORD_W constants; cmd codes CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
- One sub-module: spi_piso_tx. Holds the TX load/shift register and 8-bit bit count, drives MISO, has an abort input driven by SS_n.

Test Plan:
- Write address: SS_n low, mode 0, word 0x03C -> one-cycle rx_valid with rx_data=0x03C after E11; MISO stays 0.
- Write data: mode 0, word 0x1A5 -> rx_data=0x1A5, single rx_valid pulse; holding SS_n low 5 extra cycles gives no second pulse.
- Read sequence:
  - Frame 1: mode 1, word 0x23C -> rx_data=0x23C, rd_addr_seen=1.
  - Frame 2: mode 1, word 0x300 -> rx_data=0x300; bench RAM returns tx_data=0xA5 with tx_valid one cycle later -> MISO=1,0,1,0,0,1,0,1 on E13..E20, then 0; rd_addr_seen=0.
- Abort: SS_n rises after 5 word bits -> no rx_valid, IDLE next edge. Next mode-1 frame still routes to READ_ADD or READ_DATA per the retained flag.
- Reset mid-serialisation: rst_n low during MISO bit 3 -> MISO=0, rx_valid=0 immediately, state IDLE, rd_addr_seen=0.
- SPI_CMD_CHECK_EN: mode 0 with word 0x23C -> cmd_err pulse, no rx_valid. With the macro undefined, the same stimulus -> rx_valid, rx_data=0x23C.
